fft_butterfly: RTL and testbench

- Radix-2 decimation-in-time butterfly datapath for the FFT core.
- Sits directly downstream of the load controller. It accepts six serially loaded 16-bit words per butterfly: operand A, operand B and the twiddle W, each as a real/imag pair.
- Computes A' = (A + W·B)/2 and B' = (A − W·B)/2 in Q1.15 fixed point.
- Streams the four result words back toward SRAM through a valid/ready write handshake.

---
 rtl/fft_pkg.sv | 29 ++
 rtl/cmplx_mult_q15.sv | 46 ++++
 rtl/fft_butterfly.sv | 131 +++++++++++++
 tb/tb_fft_butterfly.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and Q1.15 constants for the radix-2 FFT butterfly datapath.
package fft_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, MULT, ADD, OUT} bf_state_t;

    localparam int unsigned NUM_SLOTS = 6;

    localparam logic [2:0] SLOT_AR = 3'd0;
    localparam logic [2:0] SLOT_AI = 3'd1;
    localparam logic [2:0] SLOT_BR = 3'd2;
    localparam logic [2:0] SLOT_BI = 3'd3;
    localparam logic [2:0] SLOT_WR = 3'd4;
    localparam logic [2:0] SLOT_WI = 3'd5;

    localparam logic signed [33:0] ROUND_HALF = 34'sd16384;
    localparam logic signed [15:0] SAT_MAX    = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN    = 16'sh8000;

    function automatic logic signed [15:0] sat_q15(input logic signed [33:0] v);
        if (v > 34'sd32767) begin
            return SAT_MAX;
        end else if (v < -34'sd32768) begin
            return SAT_MIN;
        end else begin
            return v[15:0];
        end
    endfunction

endpackage

// File: rtl/cmplx_mult_q15.sv
// Registered complex multiply t = W*B in Q1.15, with round-half-up and saturation.
module cmplx_mult_q15
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     capture,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  logic signed [DATA_W-1:0] w_re,
    input  logic signed [DATA_W-1:0] w_im,
    output logic signed [DATA_W-1:0] t_re,
    output logic signed [DATA_W-1:0] t_im
);

    localparam int unsigned PW = 2 * DATA_W;
    localparam int unsigned IW = PW + 2;

    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic signed [IW-1:0] sum_re, sum_im;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            p_rr <= '0;
            p_ii <= '0;
            p_ri <= '0;
            p_ir <= '0;
        end else if (capture) begin
            p_rr <= PW'(b_re) * PW'(w_re);
            p_ii <= PW'(b_im) * PW'(w_im);
            p_ri <= PW'(b_re) * PW'(w_im);
            p_ir <= PW'(b_im) * PW'(w_re);
        end
    end

    // Two extra bits keep -1 * -1 and the sum of two such products exact before saturation.
    always_comb begin
        sum_re = IW'(p_rr) - IW'(p_ii) + ROUND_HALF;
        sum_im = IW'(p_ri) + IW'(p_ir) + ROUND_HALF;
        t_re   = sat_q15(sum_re >>> 15);
        t_im   = sat_q15(sum_im >>> 15);
    end

endmodule

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly: serial operand load, two-cycle compute, four-word output handshake.
module fft_butterfly
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter bit          SCALE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              bf_clear,
    input  logic              load_ena,
    input  logic [2:0]        load_index,
    input  logic [DATA_W-1:0] load_value,
    output logic              bf_busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_index,
    output logic [DATA_W-1:0] out_value,
    output logic              bf_done,
    output logic              load_overrun
);

    localparam int unsigned SW = DATA_W + 2;

    bf_state_t                state_q, state_d;
    logic signed [DATA_W-1:0] ops_q [NUM_SLOTS];
    logic signed [DATA_W-1:0] res_q [4];
    logic signed [DATA_W-1:0] res_d [4];
    logic signed [SW-1:0]     sum_raw [4];
    logic signed [SW-1:0]     sum_scl [4];
    logic [NUM_SLOTS-1:0]     mask_q, mask_set;
    logic                     mask_full, load_wr, out_fire;
    logic                     out_valid_q, done_q, overrun_q;
    logic [1:0]               out_idx_q;
    logic signed [DATA_W-1:0] t_re, t_im;

    cmplx_mult_q15 #(
        .DATA_W (DATA_W)
    ) u_mult (
        .clk     (clk),
        .n_rst   (n_rst),
        .capture (state_q == MULT),
        .b_re    (ops_q[SLOT_BR]),
        .b_im    (ops_q[SLOT_BI]),
        .w_re    (ops_q[SLOT_WR]),
        .w_im    (ops_q[SLOT_WI]),
        .t_re    (t_re),
        .t_im    (t_im)
    );

    assign bf_busy      = (state_q == MULT) || (state_q == ADD) || (state_q == OUT);
    assign out_valid    = out_valid_q;
    assign out_index    = out_idx_q;
    assign out_value    = res_q[out_idx_q];
    assign bf_done      = done_q;
    assign load_overrun = overrun_q;

    always_comb begin
        load_wr   = !bf_clear && load_ena && (load_index <= SLOT_WI)
                    && ((state_q == IDLE) || (state_q == LOAD));
        mask_set  = load_wr ? (NUM_SLOTS'(1) << load_index) : '0;
        mask_full = &(mask_q | mask_set);
        out_fire  = (state_q == OUT) && out_valid_q && out_ready;

        state_d = state_q;
        if (bf_clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, LOAD: if (load_wr) state_d = mask_full ? MULT : LOAD;
                MULT:       state_d = ADD;
                ADD:        state_d = OUT;
                OUT:        if (out_fire && (out_idx_q == 2'd3)) state_d = IDLE;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Scaled mode rounds half up before the halving shift; 18 bits hold a +/- t exactly.
    always_comb begin
        sum_raw[0] = SW'(ops_q[SLOT_AR]) + SW'(t_re);
        sum_raw[1] = SW'(ops_q[SLOT_AI]) + SW'(t_im);
        sum_raw[2] = SW'(ops_q[SLOT_AR]) - SW'(t_re);
        sum_raw[3] = SW'(ops_q[SLOT_AI]) - SW'(t_im);
        for (int i = 0; i < 4; i++) begin
            sum_scl[i] = SCALE_EN ? ((sum_raw[i] + SW'(1)) >>> 1) : sum_raw[i];
            res_d[i]   = sat_q15(34'(sum_scl[i]));
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= 2'd0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) ops_q[i] <= '0;
            for (int i = 0; i < 4; i++) res_q[i] <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            if (bf_clear) begin
                mask_q      <= '0;
                out_valid_q <= 1'b0;
                out_idx_q   <= 2'd0;
                overrun_q   <= 1'b0;
            end else begin
                if (load_ena && bf_busy) overrun_q <= 1'b1;
                if (load_wr) mask_q <= mask_full ? '0 : (mask_q | mask_set);
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (load_wr && (load_index == 3'(i))) ops_q[i] <= load_value;
                end
                if (state_q == ADD) begin
                    for (int i = 0; i < 4; i++) res_q[i] <= res_d[i];
                    out_valid_q <= 1'b1;
                    out_idx_q   <= 2'd0;
                end
                if (out_fire) begin
                    out_idx_q <= out_idx_q + 2'd1;
                    if (out_idx_q == 2'd3) begin
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_butterfly.sv
// Directed bench for fft_butterfly: vector table plus clear, overrun, backpressure and reset cases.
module tb_fft_butterfly;

    typedef struct packed {
        logic [15:0] ar, ai, br, bi, wr, wi;
        logic [15:0] e0, e1, e2, e3;
        logic        rev;
    } vec_t;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        bf_clear;
    logic        load_ena;
    logic [2:0]  load_index;
    logic [15:0] load_value;
    logic        bf_busy;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_index;
    logic [15:0] out_value;
    logic        bf_done;
    logic        load_overrun;

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t vecs [5];

    always #5 clk = ~clk;

    fft_butterfly dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .bf_clear     (bf_clear),
        .load_ena     (load_ena),
        .load_index   (load_index),
        .load_value   (load_value),
        .bf_busy      (bf_busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_index    (out_index),
        .out_value    (out_value),
        .bf_done      (bf_done),
        .load_overrun (load_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},    32'(bf_busy),      32'd0);
        check({tag, "_valid"},   32'(out_valid),    32'd0);
        check({tag, "_done"},    32'(bf_done),      32'd0);
        check({tag, "_overrun"}, 32'(load_overrun), 32'd0);
        check({tag, "_index"},   32'(out_index),    32'd0);
        check({tag, "_value"},   32'(out_value),    32'd0);
    endtask

    task automatic do_load(input logic [2:0] idx, input logic [15:0] val);
        @(negedge clk);
        load_ena   = 1'b1;
        load_index = idx;
        load_value = val;
    endtask

    // Returns at the negedge of the MULT cycle, with load_ena dropped.
    task automatic load_ops(input vec_t v);
        logic [15:0] ops [6];
        int slot;
        ops = '{v.ar, v.ai, v.br, v.bi, v.wr, v.wi};
        for (int k = 0; k < 6; k++) begin
            slot = v.rev ? 5 - k : k;
            do_load(3'(slot), ops[slot]);
        end
        @(negedge clk);
        load_ena = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int cyc = 1;
        check({tag, "_busy_after_load"}, 32'(bf_busy), 32'd1);
        while (!out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, 32'd3);
    endtask

    // mode 0: always ready; mode 1: accept index 0, stall 5 cycles, then toggle ready.
    task automatic drain(input string tag, input vec_t v, input int mode);
        logic [15:0] exp_v [4];
        int got = 0, dones = 0, step = 0;
        logic rdy;
        exp_v = '{v.e0, v.e1, v.e2, v.e3};
        while (got < 4 && step < 40) begin
            if (bf_done) dones++;
            if (mode == 0 || step == 0) rdy = 1'b1;
            else if (step <= 5)         rdy = 1'b0;
            else                        rdy = (step % 2 == 0);
            out_ready = rdy;
            if (out_valid && rdy) begin
                check($sformatf("%s_idx%0d", tag, got), 32'(out_index), got);
                check($sformatf("%s_val%0d", tag, got), 32'(out_value), 32'(exp_v[got]));
                got++;
            end else if (mode == 1 && step <= 5) begin
                check($sformatf("%s_stall_valid%0d", tag, step), 32'(out_valid), 32'd1);
                check($sformatf("%s_stall_idx%0d", tag, step), 32'(out_index), 32'd1);
                check($sformatf("%s_stall_val%0d", tag, step), 32'(out_value), 32'(exp_v[1]));
            end
            step++;
            @(negedge clk);
        end
        check({tag, "_words"}, got, 32'd4);
        check({tag, "_done_pulse"}, 32'(bf_done), 32'd1);
        check({tag, "_valid_low"}, 32'(out_valid), 32'd0);
        dones += int'(bf_done);
        @(negedge clk);
        dones += int'(bf_done);
        check({tag, "_done_count"}, dones, 32'd1);
        out_ready = 1'b1;
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        load_ops(v);
        wait_valid(tag);
        drain(tag, v, 0);
    endtask

    initial begin
        vecs[0] = '{16'h4000, 16'h0000, 16'h4000, 16'h0000, 16'h7FFF, 16'h0000,
                    16'h4000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[1] = '{16'h4000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h7FFF,
                    16'h2000, 16'h2000, 16'h2000, 16'hE000, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000,
                    16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[3] = '{16'h1000, 16'h2000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000,
                    16'h47FF, 16'h1000, 16'hC801, 16'h1000, 1'b0};
        vecs[4] = '{16'h0000, 16'h0000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                    16'h0000, 16'h4000, 16'h0000, 16'hC001, 1'b1};

        n_rst      = 1'b0;
        bf_clear   = 1'b0;
        load_ena   = 1'b0;
        load_index = 3'd0;
        load_value = 16'h0;
        out_ready  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        n_rst = 1'b1;

        for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Backpressure
        load_ops(vecs[0]);
        wait_valid("bp");
        drain("bp", vecs[0], 1);

        // Overrun during OUT, then clear
        load_ops(vecs[3]);
        wait_valid("ovr");
        out_ready  = 1'b0;
        load_ena   = 1'b1;
        load_index = 3'd0;
        load_value = 16'h1234;
        @(negedge clk);
        load_ena = 1'b0;
        check("ovr_flag", 32'(load_overrun), 32'd1);
        check("ovr_idx_held", 32'(out_index), 32'd0);
        check("ovr_val_held", 32'(out_value), 32'(vecs[3].e0));
        bf_clear = 1'b1;
        @(negedge clk);
        bf_clear = 1'b0;
        check("clr_valid", 32'(out_valid), 32'd0);
        check("clr_busy", 32'(bf_busy), 32'd0);
        check("clr_overrun", 32'(load_overrun), 32'd0);
        check("clr_done", 32'(bf_done), 32'd0);
        @(negedge clk);
        check("clr_done_next", 32'(bf_done), 32'd0);
        out_ready = 1'b1;

        // A load coincident with bf_clear must not set its mask bit
        bf_clear   = 1'b1;
        load_ena   = 1'b1;
        load_index = 3'd0;
        load_value = 16'h5555;
        @(negedge clk);
        bf_clear = 1'b0;
        load_ena = 1'b0;
        do_load(3'd1, vecs[1].ai);
        do_load(3'd2, vecs[1].br);
        do_load(3'd3, vecs[1].bi);
        do_load(3'd4, vecs[1].wr);
        do_load(3'd5, vecs[1].wi);
        @(negedge clk);
        load_ena = 1'b0;
        check("clr_load_discarded", 32'(bf_busy), 32'd0);
        do_load(3'd0, vecs[1].ar);
        @(negedge clk);
        load_ena = 1'b0;
        wait_valid("post_clr");
        drain("post_clr", vecs[1], 0);

        // Asynchronous reset during MULT
        load_ops(vecs[2]);
        #2 n_rst = 1'b0;
        #1 check_idle_outputs("rst_mult");
        @(negedge clk);
        n_rst = 1'b1;
        run_vec("after_rst_mult", vecs[2]);

        // Asynchronous reset during OUT after one accepted word
        load_ops(vecs[3]);
        wait_valid("rst_out");
        @(negedge clk);
        check("rst_out_idx1", 32'(out_index), 32'd1);
        #2 n_rst = 1'b0;
        #1 check_idle_outputs("rst_out");
        @(negedge clk);
        n_rst = 1'b1;
        run_vec("after_rst_out", vecs[4]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
